// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the unified-memory arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              d_rd_en;
  logic              d_wr_en;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              freeze;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr,
           mem_wdata, freeze, busy
  );

  modport master (
    output if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr,
           mem_wdata, freeze, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and data (LDR/STR) accesses, with a fixed access latency and a pipeline freeze.
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic G_FETCH = 1'b0;
  localparam logic G_DATA  = 1'b1;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              grant_reg, grant_next;
  logic              we_reg, we_next;
  logic              last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       if_rdata_reg, if_rdata_next;
  logic [31:0]       d_rdata_reg, d_rdata_next;

  logic d_pend;
  logic pick_data;

  assign d_pend = bus.d_rd_en | bus.d_wr_en;
  // Data wins when it is alone, or when both contend and fetch was served last.
  assign pick_data = d_pend & (~bus.if_req | (last_grant_reg == G_FETCH));

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    grant_next      = grant_reg;
    we_next         = we_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.if_req | d_pend) begin
          grant_next      = pick_data ? G_DATA : G_FETCH;
          last_grant_next = pick_data ? G_DATA : G_FETCH;
          we_next         = pick_data & bus.d_wr_en;
          addr_next       = pick_data ? bus.d_addr : bus.if_addr;
          if (pick_data & bus.d_wr_en) begin
            wdata_next = bus.d_wdata;
          end
          cnt_next   = LAT_M1;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_reg == 4'd0) begin
          if (grant_reg == G_FETCH) begin
            if_rdata_next = bus.mem_rdata;
          end else if (!we_reg) begin
            d_rdata_next = bus.mem_rdata;
          end
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 4'd0;
      grant_reg      <= G_FETCH;
      we_reg         <= 1'b0;
      last_grant_reg <= G_FETCH;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      grant_reg      <= grant_next;
      we_reg         <= we_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

  // Strobes decode straight from the registered state, so reset drops them next cycle.
  assign bus.mem_en    = (state_reg == S_ACCESS);
  assign bus.mem_we    = (state_reg == S_ACCESS) & we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.if_ready  = (state_reg == S_RESP) & (grant_reg == G_FETCH);
  assign bus.d_ready   = (state_reg == S_RESP) & (grant_reg == G_DATA);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.freeze    = (bus.if_req & ~bus.if_ready) | (d_pend & ~bus.d_ready);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=2 main instance plus LATENCY=1/15 instances.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32)) bus1 ();
  mem_arbiter_if #(.ADDR_W(32)) bus15 ();

  mem_arbiter #(.LATENCY(2),  .ADDR_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.LATENCY(1),  .ADDR_W(32)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
  mem_arbiter #(.LATENCY(15), .ADDR_W(32)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

  // Word memory for the main instance; a few words are (re)loaded during reset.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 32'hE3A00014;
      mem[4] <= 32'h11111111;
      mem[8] <= 32'h22222222;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata   = mem[bus.mem_addr[11:2]];
  assign bus1.mem_rdata  = {bus1.mem_addr[15:0], 16'hBEEF};
  assign bus15.mem_rdata = {bus15.mem_addr[15:0], 16'hBEEF};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    tests++; if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.busy} !== 5'b0) begin
      failed++; $display("FAIL reset_ctrl got %b exp 00000", {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.busy}); end
    tests++; if (bus.if_rdata !== 32'h0) begin failed++; $display("FAIL reset_if_rdata got %h exp 0", bus.if_rdata); end
    tests++; if (bus.d_rdata !== 32'h0) begin failed++; $display("FAIL reset_d_rdata got %h exp 0", bus.d_rdata); end
    tests++; if (bus.mem_addr !== 32'h0) begin failed++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
    tests++; if (bus.mem_wdata !== 32'h0) begin failed++; $display("FAIL reset_mem_wdata got %h exp 0", bus.mem_wdata); end
    rst = 1'b0;
    $display("[TB] reset applied");
  endtask

  task automatic test_single_fetch(input logic [31:0] addr, input logic [31:0] exp);
    tick();
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    #1;
    tests++; if (bus.freeze !== 1'b1) begin failed++; $display("FAIL fetch_freeze_c0 got %b exp 1", bus.freeze); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      tests++; if ({bus.mem_en, bus.mem_we, bus.freeze, bus.if_ready, bus.mem_addr} !== {4'b1010, addr}) begin
        failed++; $display("FAIL fetch_access_c%0d got en/we/frz/rdy=%b addr=%h exp 1010 addr=%h", c,
                           {bus.mem_en, bus.mem_we, bus.freeze, bus.if_ready}, bus.mem_addr, addr); end
    end
    tick();
    tests++; if ({bus.if_ready, bus.mem_en, bus.freeze, bus.busy} !== 4'b1001) begin
      failed++; $display("FAIL fetch_resp got rdy/en/frz/busy=%b exp 1001", {bus.if_ready, bus.mem_en, bus.freeze, bus.busy}); end
    tests++; if (bus.if_rdata !== exp) begin failed++; $display("FAIL fetch_rdata got %h exp %h", bus.if_rdata, exp); end
    bus.if_req = 1'b0;
    tick();
    tests++; if ({bus.busy, bus.if_ready} !== 2'b00) begin
      failed++; $display("FAIL fetch_idle got busy/rdy=%b exp 00", {bus.busy, bus.if_ready}); end
    $display("[TB] fetch addr=%h rdata=%h", addr, bus.if_rdata);
  endtask

  task automatic test_store_load;
    tick();
    bus.d_addr = 32'h400; bus.d_wdata = 32'h2000; bus.d_wr_en = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h400, 32'h2000}) begin
        failed++; $display("FAIL store_access_c%0d got en/we=%b addr=%h wdata=%h exp 11 400 2000", c,
                           {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata); end
    end
    tick();
    tests++; if ({bus.d_ready, bus.mem_we, bus.if_ready} !== 3'b100) begin
      failed++; $display("FAIL store_resp got drdy/we/irdy=%b exp 100", {bus.d_ready, bus.mem_we, bus.if_ready}); end
    tests++; if (bus.d_rdata !== 32'h0) begin failed++; $display("FAIL store_d_rdata got %h exp 0", bus.d_rdata); end
    bus.d_wr_en = 1'b0;
    $display("[TB] store addr=400 wdata=2000");
    tick();
    bus.d_wdata = 32'hDEADBEEF; bus.d_rd_en = 1'b1;
    tick();
    tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h400}) begin
      failed++; $display("FAIL load_access got en/we=%b addr=%h exp 10 400", {bus.mem_en, bus.mem_we}, bus.mem_addr); end
    repeat (2) tick();
    tests++; if (bus.d_ready !== 1'b1) begin failed++; $display("FAIL load_ready got %b exp 1", bus.d_ready); end
    tests++; if (bus.d_rdata !== 32'h2000) begin failed++; $display("FAIL load_rdata got %h exp 00002000", bus.d_rdata); end
    bus.d_rd_en = 1'b0;
    $display("[TB] load addr=400 rdata=%h", bus.d_rdata);
  endtask

  task automatic test_withdraw_and_both;
    tick();
    bus.d_addr = 32'h404; bus.d_wdata = 32'h00005A5A; bus.d_rd_en = 1'b1; bus.d_wr_en = 1'b1;
    tick();
    tests++; if ({bus.mem_we, bus.mem_addr} !== {1'b1, 32'h404}) begin
      failed++; $display("FAIL both_is_write got we=%b addr=%h exp 1 404", bus.mem_we, bus.mem_addr); end
    bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0; bus.d_addr = 32'h999;
    tick();
    tests++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h404}) begin
      failed++; $display("FAIL addr_hold got en=%b addr=%h exp 1 404", bus.mem_en, bus.mem_addr); end
    tick();
    tests++; if ({bus.d_ready, bus.freeze} !== 2'b10) begin
      failed++; $display("FAIL withdraw_ready got rdy/frz=%b exp 10", {bus.d_ready, bus.freeze}); end
    tests++; if (bus.d_rdata !== 32'h2000) begin failed++; $display("FAIL write_keeps_d_rdata got %h exp 00002000", bus.d_rdata); end
    tick();
    $display("[TB] withdrawn write addr=404 completed");
  endtask

  task automatic test_contention;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.if_addr = 32'h8; bus.d_addr = 32'h400; bus.if_req = 1'b1; bus.d_rd_en = 1'b1;
    tick();
    tests++; if (bus.mem_addr !== 32'h400) begin failed++; $display("FAIL contention_first got %h exp 00000400", bus.mem_addr); end
    repeat (2) tick();
    tests++; if ({bus.d_ready, bus.if_ready, bus.freeze} !== 3'b101) begin
      failed++; $display("FAIL contention_d_ready got drdy/irdy/frz=%b exp 101", {bus.d_ready, bus.if_ready, bus.freeze}); end
    bus.d_rd_en = 1'b0;
    tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL contention_idle got busy=%b exp 0", bus.busy); end
    tick();
    tests++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h8}) begin
      failed++; $display("FAIL contention_second got en=%b addr=%h exp 1 8", bus.mem_en, bus.mem_addr); end
    repeat (2) tick();
    tests++; if ({bus.if_ready, bus.if_rdata, bus.d_rdata} !== {1'b1, 32'hE3A00014, 32'h2000}) begin
      failed++; $display("FAIL contention_if_ready got rdy=%b if_rdata=%h d_rdata=%h exp 1 e3a00014 00002000",
                         bus.if_ready, bus.if_rdata, bus.d_rdata); end
    bus.if_req = 1'b0;
    tick();
    $display("[TB] contention: data then fetch in 8 cycles");
  endtask

  task automatic test_fairness;
    logic [31:0] grants [4];
    logic [31:0] exp_g  [4];
    int n = 0;
    logic prev_en = 1'b0;
    exp_g[0] = 32'h20; exp_g[1] = 32'h10; exp_g[2] = 32'h20; exp_g[3] = 32'h10;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.if_addr = 32'h10; bus.d_addr = 32'h20; bus.if_req = 1'b1; bus.d_rd_en = 1'b1;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      if (bus.mem_en && !prev_en) begin
        grants[n] = bus.mem_addr;
        n++;
      end
      prev_en = bus.mem_en;
    end
    bus.if_req = 1'b0; bus.d_rd_en = 1'b0;
    tests++; if (n !== 4) begin failed++; $display("FAIL fair_grant_count got %0d exp 4", n); end
    for (int i = 0; i < n; i++) begin
      tests++; if (grants[i] !== exp_g[i]) begin failed++; $display("FAIL fair_grant%0d got %h exp %h", i, grants[i], exp_g[i]); end
      $display("[TB] fairness grant %0d addr=%h", i, grants[i]);
    end
    repeat (4) tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL fair_idle got busy=%b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    tick();
    bus.if_addr = 32'h8; bus.if_req = 1'b1;
    tick();
    tick();
    tests++; if (bus.mem_en !== 1'b1) begin failed++; $display("FAIL rstmid_access got en=%b exp 1", bus.mem_en); end
    rst = 1'b1;
    tick();
    tests++; if ({bus.mem_en, bus.busy, bus.if_ready} !== 3'b000) begin
      failed++; $display("FAIL rstmid_abort got en/busy/rdy=%b exp 000", {bus.mem_en, bus.busy, bus.if_ready}); end
    tests++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
      failed++; $display("FAIL rstmid_rdata got if=%h d=%h exp 0 0", bus.if_rdata, bus.d_rdata); end
    rst = 1'b0; bus.if_req = 1'b0;
    tick();
    tests++; if ({bus.if_ready, bus.busy} !== 2'b00) begin
      failed++; $display("FAIL rstmid_no_pulse got rdy/busy=%b exp 00", {bus.if_ready, bus.busy}); end
    $display("[TB] reset mid-access aborted fetch");
    test_single_fetch(32'h8, 32'hE3A00014);
  endtask

  task automatic test_latency_builds;
    int en1 = 0, en15 = 0, rdy1 = -1, rdy15 = -1;
    logic [31:0] rd1 = '0, rd15 = '0;
    tick();
    bus1.if_addr = 32'h30; bus1.if_req = 1'b1;
    bus15.if_addr = 32'h34; bus15.if_req = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      en1  += int'(bus1.mem_en);
      en15 += int'(bus15.mem_en);
      if (bus1.if_ready) begin rdy1 = k; rd1 = bus1.if_rdata; bus1.if_req = 1'b0; end
      if (bus15.if_ready) begin rdy15 = k; rd15 = bus15.if_rdata; bus15.if_req = 1'b0; end
    end
    bus1.if_req = 1'b0; bus15.if_req = 1'b0;
    tests++; if (rdy1 !== 2) begin failed++; $display("FAIL lat1_ready_cycle got %0d exp 2", rdy1); end
    tests++; if (en1 !== 1) begin failed++; $display("FAIL lat1_en_width got %0d exp 1", en1); end
    tests++; if (rd1 !== 32'h0030BEEF) begin failed++; $display("FAIL lat1_rdata got %h exp 0030beef", rd1); end
    tests++; if (rdy15 !== 16) begin failed++; $display("FAIL lat15_ready_cycle got %0d exp 16", rdy15); end
    tests++; if (en15 !== 15) begin failed++; $display("FAIL lat15_en_width got %0d exp 15", en15); end
    tests++; if (rd15 !== 32'h0034BEEF) begin failed++; $display("FAIL lat15_rdata got %h exp 0034beef", rd15); end
    $display("[TB] latency builds: L1 ready@%0d en=%0d, L15 ready@%0d en=%0d", rdy1, en1, rdy15, en15);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_rd_en = 1'b0; bus1.d_wr_en = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    bus15.if_req = 1'b0; bus15.if_addr = '0; bus15.d_rd_en = 1'b0; bus15.d_wr_en = 1'b0;
    bus15.d_addr = '0; bus15.d_wdata = '0;
    test_reset();
    test_single_fetch(32'h8, 32'hE3A00014);
    test_store_load();
    test_withdraw_and_both();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_latency_builds();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
